jtframe_db15_joy: RTL

- Serial reader for the SNAC DB15 joystick adapter on the MiSTer user port.
- Drives the adapter's load and shift-clock lines and captures 24 serial bits: 12 per player.
- Presents two active-high player words to the frame input logic, which merges them with the HPS joysticks.
- Sits between the user-port pins (JOY_CLK, JOY_LOAD, JOY_DATA) and the joystick path of the MiSTer frame.

---
 rtl/jtframe_db15_joy.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/jtframe_db15_joy.sv
// Serial reader for the SNAC DB15 joystick adapter. It pulses the parallel load,
// clocks 24 bits out of the adapter and presents two active-high 12-bit player words.
module jtframe_db15_joy #(
  parameter int unsigned CLKDIV = 48,
  parameter int unsigned GAP    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [11:0] joy1,
  output logic [11:0] joy2,
  output logic        frame_done
);

  localparam logic [15:0] DivLast = 16'(CLKDIV - 1);
  localparam logic [15:0] GapLast = 16'(GAP - 1);
  localparam logic [4:0]  LastBit = 5'd23;

  typedef enum logic [2:0] {StIdle, StLoad, StHigh, StLow, StDone, StGap} state_e;

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] gap_q, gap_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] sr_q, sr_d;
  logic [11:0] joy1_q, joy1_d;
  logic [11:0] joy2_q, joy2_d;
  logic        done_q, done_d;
  logic [1:0]  sync_q;
  logic        tick;

  // Two-flop synchroniser for the asynchronous adapter data line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], joy_data};
  end

  // Phase divider: held at zero while disabled so re-enabling starts a clean phase.
  assign tick = (div_q == DivLast);

  always_comb begin
    div_d = '0;
    if (enable && !tick) div_d = div_q + 16'd1;
  end

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      joy1_q  <= '0;
      joy2_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; disable overrides everything and discards the partial frame.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;
    done_d  = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      gap_d   = '0;
      bit_d   = '0;
      sr_d    = '0;
      joy1_d  = '0;
      joy2_d  = '0;
    end else if (tick) begin
      unique case (state_q)
        StIdle: state_d = StLoad;
        StLoad: begin
          state_d = StHigh;
          bit_d   = '0;
        end
        StHigh: begin
          sr_d[bit_q] = sync_q[1];
          if (bit_q == LastBit) begin
            // Words are latched on the edge entering DONE so they and the pulse
            // become visible together in DONE's first cycle.
            state_d = StDone;
            joy1_d  = ~sr_d[11:0];
            joy2_d  = ~sr_d[23:12];
            done_d  = 1'b1;
          end else begin
            state_d = StLow;
          end
        end
        StLow: begin
          state_d = StHigh;
          bit_d   = bit_q + 5'd1;
        end
        StDone: begin
          state_d = StGap;
          gap_d   = '0;
        end
        StGap: begin
          if (gap_q == GapLast) state_d = StLoad;
          else                  gap_d   = gap_q + 16'd1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Line drivers decoded from state so an async reset idles them immediately.
  always_comb begin
    joy_clk  = 1'b1;
    joy_load = 1'b1;
    case (state_q)
      StLoad:  joy_load = 1'b0;
      StLow:   joy_clk  = 1'b0;
      default: ;
    endcase
  end

  assign joy1       = joy1_q;
  assign joy2       = joy2_q;
  assign frame_done = done_q;

endmodule
